// File: rtl/product_bcd_converter_pkg.sv
// Shared types and constants for the signed-product-to-BCD converter.
// Holds the FSM state enum, digit constants and the step-counter width helper.
package product_bcd_converter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int         BCD_DIGITS         = 3;
  localparam logic [3:0] BCD_ADD3_THRESHOLD = 4'd5;

  // Counter must reach WIDTH, so it needs clog2(WIDTH+1) bits.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/product_bcd_converter_bcd_add3.sv
// Combinational double-dabble digit corrector: adds 3 to any digit of 5 or more
// so that the following left shift carries correctly into the next decade.
module bcd_add3
  import product_bcd_converter_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] corrected
);

  assign corrected = (digit >= BCD_ADD3_THRESHOLD) ? digit + 4'd3 : digit;

endmodule

// File: rtl/product_bcd_converter.sv
// Iterative signed-binary to 3-digit BCD converter (shift-add-3), one bit per cycle.
// Optional macro BCD_EDGE_START_EN makes start rising-edge triggered instead of level.
module product_bcd_converter
  import product_bcd_converter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic signed [WIDTH-1:0]   product,
  output logic                      busy,
  output logic                      valid,
  output logic                      sign,
  output logic [4*BCD_DIGITS-1:0]   bcd
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam int BCD_W = 4 * BCD_DIGITS;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   mag_q, mag_next;
  logic [BCD_W-1:0]   digits_q, digits_corr, digits_next;
  logic               neg_q;
  logic               start_req, accept, last_step;

  // Widen by one bit so the most negative product negates to a positive magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] p);
    logic signed [WIDTH:0] wide;
    wide = (WIDTH+1)'(p);
    if (wide < 0) wide = -wide;
    return wide[WIDTH-1:0];
  endfunction

`ifdef BCD_EDGE_START_EN
  logic start_prev_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) start_prev_q <= 1'b0;
    else      start_prev_q <= start;
  end
  assign start_req = start & ~start_prev_q;
`else
  assign start_req = start;
`endif

  assign accept    = (state_q == IDLE) && start_req;
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit     (digits_q[4*g +: 4]),
      .corrected (digits_corr[4*g +: 4])
    );
  end

  assign {digits_next, mag_next} = {digits_corr[BCD_W-2:0], mag_q, 1'b0};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = SHIFT;
      SHIFT:   if (last_step) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == SHIFT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      mag_q    <= '0;
      digits_q <= '0;
      neg_q    <= 1'b0;
      valid    <= 1'b0;
      sign     <= 1'b0;
      bcd      <= '0;
    end else if (accept) begin
      mag_q    <= magnitude(product);
      neg_q    <= product[WIDTH-1];
      digits_q <= '0;
      cnt_q    <= '0;
      valid    <= 1'b0;
    end else if (state_q == SHIFT) begin
      digits_q <= digits_next;
      mag_q    <= mag_next;
      cnt_q    <= cnt_q + CNT_W'(1);
      // Outputs only move on completion so the display never sees partial digits.
      if (last_step) begin
        bcd   <= digits_next;
        sign  <= neg_q;
        valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_product_bcd_converter.sv
// Self-checking bench for product_bcd_converter: arithmetic reference model,
// per-cycle output compare, directed literal cases and randomized traffic.
module tb_product_bcd_converter;

  localparam int WIDTH = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic signed [7:0] product = '0;
  logic              busy, valid, sign;
  logic [11:0]       bcd;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  product_bcd_converter #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .product (product),
    .busy    (busy),
    .valid   (valid),
    .sign    (sign),
    .bcd     (bcd)
  );

  // Reference: decimal digits of |product| by plain integer arithmetic.
  function automatic logic [11:0] ref_bcd(input logic [7:0] p);
    int v;
    v = $signed(p);
    if (v < 0) v = -v;
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  int          m_left;
  logic        m_valid, m_sign, m_pend_sign, m_prev_start, m_req;
  logic [11:0] m_bcd, m_pend_bcd;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_left = 0; m_valid = 1'b0; m_sign = 1'b0; m_bcd = '0; m_prev_start = 1'b0;
    end else begin
`ifdef BCD_EDGE_START_EN
      m_req = start && !m_prev_start;
`else
      m_req = start;
`endif
      m_prev_start = start;
      if (m_left == 0) begin
        if (m_req) begin
          m_left      = WIDTH;
          m_valid     = 1'b0;
          m_pend_bcd  = ref_bcd(product);
          m_pend_sign = product[7];
        end
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_valid = 1'b1;
          m_bcd   = m_pend_bcd;
          m_sign  = m_pend_sign;
        end
      end
    end
  end

  always @(negedge clk) begin
    n_vec++;
    if (busy !== (m_left != 0) || valid !== m_valid || sign !== m_sign || bcd !== m_bcd) begin
      n_err++;
      $display("FAIL cycle_check t=%0t actual busy=%b valid=%b sign=%b bcd=%h required busy=%b valid=%b sign=%b bcd=%h",
               $time, busy, valid, sign, bcd, (m_left != 0), m_valid, m_sign, m_bcd);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_idle(input string name);
    int guard;
    guard = 0;
    while (busy && guard < 20) begin
      guard++;
      @(negedge clk);
    end
    if (busy) check({name, "_timeout"}, 32'(busy), 32'd0);
  endtask

  task automatic run_one(input logic [7:0] p, input logic exp_sign, input logic [11:0] exp_bcd,
                         input string name);
    int busy_cycles;
    @(negedge clk); start = 1'b1; product = p;
    @(negedge clk); start = 1'b0;
    busy_cycles = 0;
    while (busy && busy_cycles < 20) begin
      busy_cycles++;
      @(negedge clk);
    end
    check({name, "_busy_cycles"}, 32'(busy_cycles), 32'(WIDTH));
    check({name, "_valid"}, 32'(valid), 32'd1);
    check({name, "_sign"}, 32'(exp_sign), 32'(sign) ^ 32'd0);
    check({name, "_bcd"}, 32'(bcd), 32'(exp_bcd));
  endtask

  initial begin
    int rises;
    logic pv;
    logic [7:0] held_p;

    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_sign", 32'(sign), 32'd0);
    check("reset_bcd", 32'(bcd), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run_one(8'h2A, 1'b0, 12'h042, "p42");
    run_one(8'hFF, 1'b1, 12'h001, "m1");
    run_one(8'h00, 1'b0, 12'h000, "zero");
    run_one(8'h7F, 1'b0, 12'h127, "p127");

    // A second start while converting must be dropped.
    @(negedge clk); start = 1'b1; product = 8'h31;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; product = 8'h05;
    @(negedge clk); start = 1'b0;
    wait_idle("ignore");
    check("ignore_bcd", 32'(bcd), 32'h049);
    check("ignore_sign", 32'(sign), 32'd0);
    repeat (12) @(negedge clk);
    check("ignore_no_second_busy", 32'(busy), 32'd0);
    check("ignore_valid_held", 32'(valid), 32'd1);

    run_one(8'h80, 1'b1, 12'h128, "m128");

    // Asynchronous reset in the middle of a conversion.
    @(negedge clk); start = 1'b1; product = 8'h2A;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #2 rst = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_valid", 32'(valid), 32'd0);
    check("async_rst_sign", 32'(sign), 32'd0);
    check("async_rst_bcd", 32'(bcd), 32'd0);
    @(negedge clk); rst = 1'b1;
    run_one(8'hF7, 1'b1, 12'h009, "m9");

    // Held start: one conversion when edge-triggered, back-to-back otherwise.
    held_p = 8'($urandom);
    @(negedge clk); start = 1'b1; product = held_p;
    pv = valid; rises = 0;
    repeat (30) begin
      @(negedge clk);
      if (valid && !pv) rises++;
      pv = valid;
    end
    start = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (valid && !pv) rises++;
      pv = valid;
    end
`ifdef BCD_EDGE_START_EN
    check("held_start_rises", 32'(rises), 32'd1);
`else
    check("held_start_rises", 32'(rises), 32'd4);
`endif
    check("held_start_bcd", 32'(bcd), 32'(ref_bcd(held_p)));

    // Random traffic with occasional asynchronous reset pulses.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      start   = ($urandom_range(0, 3) == 0);
      product = 8'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        #2 rst = 1'b0;
        #1 rst = 1'b1;
      end
    end
    @(negedge clk); start = 1'b0;
    repeat (12) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/product_bcd_converter.md
# product_bcd_converter

Sequential signed-binary-to-BCD converter that sits directly downstream of the 4x4 Booth multiplier. It consumes the multiplier's 8-bit two's-complement product when the multiplier signals completion. It produces a sign flag plus three BCD digits (hundreds/tens/ones) for the lab board's seven-segment display driver, using an iterative shift-add-3 (double-dabble) datapath.

## Interface
- WIDTH, 8: product width in bits; the digit count is fixed at 3, which is sufficient for |product| ≤ 128.
- clk  in  1  system clock; rising-edge active.
- rst  in  1  reset; **asynchronous, active-low** (rst=0 resets).
- start  in  1  conversion request; driven from the multiplier's done.
- product  in  WIDTH  signed two's-complement product; sampled only on the accepting edge.
- busy  out  1  conversion in progress.
- valid  out  1  sign/bcd hold a completed conversion.
- sign  out  1  1 = product was negative.
- bcd  out  12  {hundreds, tens, ones}, 4 bits each.

## Operation
- States: IDLE, SHIFT.
- IDLE, start accepted:
  - Latch magnitude = product[WIDTH-1] ? -product : product, computed in WIDTH+1 bits so that 8'h80 gives 128.
  - Latch the sign bit.
  - Clear the digit scratch register and the step counter.
  - Set busy=1 and valid=0, then go to SHIFT.
- SHIFT, once per cycle:
  - Each digit ≥ 5 gets +3.
  - Then shift {digits, magnitude} left by 1.
  - Increment the counter.
- After the WIDTH-th step:
  - Register the scratch digits to bcd and the latched sign to sign.
  - Set valid=1 and busy=0, then return to IDLE.
- bcd and sign hold the last completed result until the next completion; they do not change mid-conversion.
- valid stays high until the next start is accepted or a reset occurs.
- start while busy=1 is ignored; no queueing.
- A zero product yields sign=0 and bcd=12'h000. Negative zero cannot occur.
- Reset (rst=0, any time, including mid-SHIFT):
  - state=IDLE, busy=0, valid=0, sign=0, bcd=0, and all scratch registers=0.
  - Any in-flight conversion is discarded.

## Timing
- Reset values: busy=0, valid=0, sign=0, bcd=12'h000.
- Edge E0 accepts start. Edges E1..E8 perform the 8 shift steps (WIDTH=8).
- At E8: bcd, sign and valid=1 update together, and busy falls.
- busy is high from after E0 to before E8; latency is WIDTH edges after the accepting edge.
- The earliest next acceptance is E9; start asserted at E8 itself is ignored because the state is still SHIFT.
- No combinational path from inputs to outputs.

## Configuration
- Macro: BCD_EDGE_START_EN.
- With the macro defined:
  - start is registered internally; acceptance requires a 0→1 transition observed in IDLE.
  - A level-held done therefore triggers exactly one conversion.
  - The edge-detect register resets to 0, so start already high out of reset counts as a rising edge.
- Without the macro: start is level-sensitive. Every IDLE cycle with start=1 begins a new conversion, so a held start reconverts back-to-back every WIDTH+1 cycles.

## Structure
- Shared package holds:
  - the state enum (IDLE, SHIFT);
  - constant BCD_DIGITS=3;
  - constant BCD_ADD3_THRESHOLD=4'd5;
  - counter width $clog2(WIDTH+1).
- One sub-module, bcd_add3: a combinational 4-bit digit corrector (out = in ≥ 5 ? in+3 : in). It is instantiated once per digit in the SHIFT path.
- Top level holds the state register, counter, magnitude/scratch shift register and output registers.

## Test plan
- product=8'h2A, start pulse → at E8: valid=1, sign=0, bcd=12'h042; busy high for exactly E1..E7 observation window.
- product=8'h80 (-128) → sign=1, bcd=12'h128.
- product=8'hFF (-1) → sign=1, bcd=12'h001. Also product=8'h00 → sign=0, bcd=12'h000. Also product=8'h7F → sign=0, bcd=12'h127.
- Start pulse at E3 with product=8'h05 during a conversion of 8'h31 → ignored; the result is bcd=12'h049 and no second conversion occurs.
- rst=0 at E4 mid-conversion → busy, valid, sign and bcd immediately 0 (asynchronously). After release, a new conversion of 8'hF7 gives sign=1, bcd=12'h009.
- With BCD_EDGE_START_EN, start held high for 30 cycles → exactly one valid rise. Without the macro, the same stimulus gives repeated conversions every 9 cycles.
